ni_depkt: RTL and testbench

NI_DEPKT -- requirements
Module: ni_depkt

---
 rtl/ni_depkt.sv | 189 ++++++++++++++++++
 tb/tb_ni_depkt.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_depkt.sv
`default_nettype none
// ============================================================================
// Module   : ni_depkt
// Brief    : NoC network-interface depacketizer, flit stream to core word stream
// Revision : 1.0
// ============================================================================
module ni_depkt #(
    parameter logic [1:0] LOCAL_X = 2'd0,
    parameter logic [1:0] LOCAL_Y = 2'd0,
    parameter int         MAX_LEN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [33:0] flit_in,
    input  logic        flit_valid,
    output logic        flit_ready,
    output logic [31:0] core_data,
    output logic        core_valid,
    input  logic        core_ready,
    output logic        core_last,
    output logic [3:0]  core_src,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RECV    = 2'd1;
    localparam logic [1:0] c_DELIVER = 2'd2;
    localparam logic [1:0] c_DROP    = 2'd3;

    localparam logic [1:0] c_T_HEAD = 2'b00;
    localparam logic [1:0] c_T_BODY = 2'b01;
    localparam logic [1:0] c_T_TAIL = 2'b10;
    localparam logic [1:0] c_T_HT   = 2'b11;

    localparam logic [1:0] c_E_DEST  = 2'd1;
    localparam logic [1:0] c_E_PROTO = 2'd2;
    localparam logic [1:0] c_E_LEN   = 2'd3;

    localparam logic [3:0] c_MAX_LEN = 4'(MAX_LEN);

    logic [1:0]  r_state, w_state;
    logic [3:0]  r_len, w_len;
    logic [3:0]  r_src, w_src;
    logic [3:0]  r_count, w_count;
    logic [3:0]  r_rd, w_rd;
    logic        r_err, w_err;
    logic [1:0]  r_code, w_code;
    logic        w_wr;
    logic [31:0] r_buf [0:15];

    logic [1:0]  w_type;
    logic        w_fire;
    logic        w_is_head;
    logic        w_dest_ok;
    logic [3:0]  w_hlen;
    logic [3:0]  w_last_idx;

    assign w_type     = flit_in[33:32];
    assign w_is_head  = (w_type == c_T_HEAD) || (w_type == c_T_HT);
    assign w_dest_ok  = (flit_in[31:28] == {LOCAL_X, LOCAL_Y});
    assign w_hlen     = flit_in[23:20];
    assign w_last_idx = r_len - 4'd1;

    assign flit_ready = (r_state != c_DELIVER);
    assign w_fire     = flit_valid && flit_ready;

    assign core_valid = (r_state == c_DELIVER);
    assign core_data  = core_valid ? r_buf[r_rd] : 32'd0;
    assign core_last  = core_valid && (r_rd == w_last_idx);
    assign core_src   = r_src;
    assign err        = r_err;
    assign err_code   = r_code;

    always_comb begin
        w_state = r_state;
        w_len   = r_len;
        w_src   = r_src;
        w_count = r_count;
        w_rd    = r_rd;
        w_err   = 1'b0;
        w_code  = r_code;
        w_wr    = 1'b0;
        case (r_state)
            c_IDLE, c_RECV: begin
                if (w_fire && (r_state == c_RECV) && !w_is_head) begin
                    if (w_type == c_T_BODY) begin
                        if (r_count < w_last_idx) begin
                            w_wr    = 1'b1;
                            w_count = r_count + 4'd1;
                        end else begin
                            w_err   = 1'b1;
                            w_code  = c_E_LEN;
                            w_state = c_DROP;
                        end
                    end else if (r_count == w_last_idx) begin
                        w_wr    = 1'b1;
                        w_rd    = 4'd0;
                        w_state = c_DELIVER;
                    end else begin
                        w_err   = 1'b1;
                        w_code  = c_E_LEN;
                        w_state = c_IDLE;
                    end
                end else if (w_fire) begin
                    // A header arriving mid-packet abandons it; a fault in the new
                    // header itself then overrides the protocol code.
                    if (r_state == c_RECV) begin
                        w_err   = 1'b1;
                        w_code  = c_E_PROTO;
                        w_state = c_IDLE;
                    end
                    case (w_type)
                        c_T_HEAD: begin
                            if (!w_dest_ok) begin
                                w_err   = 1'b1;
                                w_code  = c_E_DEST;
                                w_state = c_DROP;
                            end else if ((w_hlen == 4'd0) || (w_hlen > c_MAX_LEN)) begin
                                w_err   = 1'b1;
                                w_code  = c_E_LEN;
                                w_state = c_DROP;
                            end else begin
                                w_len   = w_hlen;
                                w_src   = flit_in[27:24];
                                w_count = 4'd0;
                                w_state = c_RECV;
                            end
                        end
                        c_T_HT: begin
                            if (!w_dest_ok) begin
                                w_err  = 1'b1;
                                w_code = c_E_DEST;
                            end
                        end
                        default: begin
                            w_err  = 1'b1;
                            w_code = c_E_PROTO;
                        end
                    endcase
                end
            end
            c_DROP: begin
                if (w_fire && ((w_type == c_T_TAIL) || (w_type == c_T_HT))) begin
                    w_state = c_IDLE;
                end
            end
            default: begin
                if (core_ready) begin
                    if (core_last) begin
                        w_rd    = 4'd0;
                        w_state = c_IDLE;
                    end else begin
                        w_rd = r_rd + 4'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
            r_len   <= 4'd0;
            r_src   <= 4'd0;
            r_count <= 4'd0;
            r_rd    <= 4'd0;
            r_err   <= 1'b0;
            r_code  <= 2'd0;
        end else begin
            r_state <= w_state;
            r_len   <= w_len;
            r_src   <= w_src;
            r_count <= w_count;
            r_rd    <= w_rd;
            r_err   <= w_err;
            r_code  <= w_code;
        end
    end

    // Payload store is deliberately left without reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_buf[r_count] <= flit_in[31:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ni_depkt.sv
`default_nettype none
// ============================================================================
// Module   : tb_ni_depkt
// Brief    : randomized packet-level reference check of ni_depkt
// Revision : 1.0
// ============================================================================
module tb_ni_depkt;

    localparam logic [1:0] LX = 2'd1;
    localparam logic [1:0] LY = 2'd2;
    localparam int         ML = 8;
    localparam int         NCYC = 4000;

    localparam int M_IDLE = 0;
    localparam int M_COLLECT = 1;
    localparam int M_DELIVER = 2;
    localparam int M_DROP = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [33:0] flit_in = 34'd0;
    logic        flit_valid = 1'b0;
    logic        core_ready = 1'b0;
    logic        flit_ready;
    logic [31:0] core_data;
    logic        core_valid;
    logic        core_last;
    logic [3:0]  core_src;
    logic        err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    ni_depkt #(.LOCAL_X(LX), .LOCAL_Y(LY), .MAX_LEN(ML)) dut (
        .clk(clk), .reset(reset),
        .flit_in(flit_in), .flit_valid(flit_valid), .flit_ready(flit_ready),
        .core_data(core_data), .core_valid(core_valid), .core_ready(core_ready),
        .core_last(core_last), .core_src(core_src),
        .err(err), .err_code(err_code)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: packets as queues of words.
    int          m_mode;
    logic [31:0] m_got[$];
    logic [31:0] m_out[$];
    int          m_want;
    int          m_plen;
    logic [3:0]  m_src;
    logic        m_err;
    logic [1:0]  m_code;
    logic [33:0] stim[$];

    function automatic logic [33:0] mk_head(input logic [1:0] ty, input logic [3:0] dest,
                                            input logic [3:0] src, input logic [3:0] len);
        logic [19:0] r;
        r = 20'($urandom());
        return {ty, dest, src, len, r};
    endfunction

    function automatic logic [33:0] mk_flit(input logic [1:0] ty);
        logic [31:0] p;
        p = $urandom();
        return {ty, p};
    endfunction

    task automatic raise(input logic [1:0] c);
        m_err  = 1'b1;
        m_code = c;
    endtask

    task automatic model_head(input logic [33:0] f);
        logic match;
        match = (f[31:28] == {LX, LY});
        if (f[33:32] == 2'b11) begin
            if (!match) raise(2'd1);
        end else if (!match) begin
            raise(2'd1);
            m_mode = M_DROP;
        end else if (f[23:20] == 4'd0 || int'(f[23:20]) > ML) begin
            raise(2'd3);
            m_mode = M_DROP;
        end else begin
            m_want = int'(f[23:20]);
            m_src  = f[27:24];
            m_got.delete();
            m_mode = M_COLLECT;
        end
    endtask

    task automatic model_accept(input logic [33:0] f);
        logic hd;
        hd = (f[33:32] == 2'b00) || (f[33:32] == 2'b11);
        if (m_mode == M_COLLECT && hd) begin
            raise(2'd2);
            m_got.delete();
            m_mode = M_IDLE;
        end
        if (m_mode == M_IDLE) begin
            if (hd) model_head(f);
            else raise(2'd2);
        end else if (m_mode == M_COLLECT) begin
            if (f[33:32] == 2'b01) begin
                if (m_got.size() < m_want - 1) m_got.push_back(f[31:0]);
                else begin raise(2'd3); m_mode = M_DROP; end
            end else if (m_got.size() == m_want - 1) begin
                m_got.push_back(f[31:0]);
                m_out  = m_got;
                m_plen = m_out.size();
                m_got.delete();
                m_mode = M_DELIVER;
            end else begin
                raise(2'd3);
                m_got.delete();
                m_mode = M_IDLE;
            end
        end else if (m_mode == M_DROP) begin
            if (f[33:32] == 2'b10 || f[33:32] == 2'b11) m_mode = M_IDLE;
        end
    endtask

    task automatic push_packet(input logic [3:0] dest, input logic [3:0] len, input int nbody, input bit tail);
        stim.push_back(mk_head(2'b00, dest, 4'($urandom()), len));
        for (int i = 0; i < nbody; i++) stim.push_back(mk_flit(2'b01));
        if (tail) stim.push_back(mk_flit(2'b10));
    endtask

    task automatic gen_scenario();
        int          kind;
        int          len;
        logic [3:0]  here;
        logic [3:0]  other;
        here  = {LX, LY};
        other = here ^ 4'($urandom_range(15, 1));
        kind  = $urandom_range(9);
        len   = $urandom_range(ML, 1);
        case (kind)
            0, 1, 2, 3: push_packet(here, 4'(len), len - 1, 1'b1);
            4: push_packet(other, 4'(len), len - 1, 1'b1);
            5: push_packet(here, ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15, ML + 1)),
                           $urandom_range(2), 1'b1);
            6: push_packet(here, 4'(len), len, 1'b1);
            7: push_packet(here, 4'($urandom_range(ML, 2)), 0, 1'b1);
            8: begin
                case ($urandom_range(3))
                    0: stim.push_back(mk_head(2'b11, here, 4'($urandom()), 4'($urandom())));
                    1: stim.push_back(mk_head(2'b11, other, 4'($urandom()), 4'($urandom())));
                    2: stim.push_back(mk_flit(2'b01));
                    default: stim.push_back(mk_flit(2'b10));
                endcase
            end
            default: push_packet(here, 4'($urandom_range(ML, 2)), 0, 1'b0);
        endcase
    endtask

    task automatic check_outputs();
        check("flit_ready", 64'(flit_ready), 64'(m_mode != M_DELIVER));
        check("core_valid", 64'(core_valid), 64'(m_mode == M_DELIVER));
        if (m_mode == M_DELIVER) begin
            check("core_data", 64'(core_data), 64'(m_out[0]));
            check("core_last", 64'(core_last), 64'(m_out.size() == 1));
            check("core_src", 64'(core_src), 64'(m_src));
        end else begin
            check("core_last_idle", 64'(core_last), 64'd0);
        end
        check("err", 64'(err), 64'(m_err));
        check("err_code", 64'(err_code), 64'(m_code));
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_got.delete();
        m_out.delete();
        m_want = 0;
        m_plen = 0;
        m_src  = 4'd0;
        m_err  = 1'b0;
        m_code = 2'd0;
    endtask

    initial begin
        bit did_rst;
        did_rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_core_valid", 64'(core_valid), 64'd0);
        check("rst_core_data", 64'(core_data), 64'd0);
        check("rst_core_src", 64'(core_src), 64'd0);
        check("rst_core_last", 64'(core_last), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_err_code", 64'(err_code), 64'd0);
        reset = 1'b1;

        // Fixed opening: clean 3-word packet from (2,1), stray BODY, abandoned packet.
        stim.push_back(mk_head(2'b00, {LX, LY}, 4'b1001, 4'd3));
        stim.push_back(mk_flit(2'b01));
        stim.push_back(mk_flit(2'b01));
        stim.push_back(mk_flit(2'b10));
        stim.push_back(mk_flit(2'b01));
        push_packet({LX, LY}, 4'd2, 1, 1'b0);
        push_packet({LX, LY}, 4'd1, 0, 1'b1);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            check_outputs();
            if (!did_rst && cyc > NCYC / 2 && m_mode == M_DELIVER && m_out.size() < m_plen) begin
                reset = 1'b0;
                flit_valid = 1'b0;
                #1;
                check("rst_mid_core_valid", 64'(core_valid), 64'd0);
                check("rst_mid_err_code", 64'(err_code), 64'd0);
                check("rst_mid_flit_ready", 64'(flit_ready), 64'd1);
                model_reset();
                stim.delete();
                @(negedge clk);
                reset = 1'b1;
                did_rst = 1'b1;
                continue;
            end
            if (stim.size() == 0) gen_scenario();
            flit_valid = ($urandom_range(3) != 0);
            flit_in    = stim[0];
            core_ready = ($urandom_range(9) < 7);
            m_err = 1'b0;
            if (m_mode == M_DELIVER) begin
                if (core_ready) begin
                    void'(m_out.pop_front());
                    if (m_out.size() == 0) m_mode = M_IDLE;
                end
            end else if (flit_valid) begin
                model_accept(stim[0]);
                void'(stim.pop_front());
            end
            @(negedge clk);
        end
        check("reset_during_deliver_exercised", 64'(did_rst), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
